// File: rtl/rel_cmp_pkg.sv
// Shared op encodings, FSM state type and defaults for the relational compare unit.
package rel_cmp_pkg;

   localparam int REL_DEF_WIDTH = 32;
   localparam int REL_DEF_CHUNK = 8;

   localparam logic [2:0] REL_EQ = 3'd0;
   localparam logic [2:0] REL_NE = 3'd1;
   localparam logic [2:0] REL_LT = 3'd2;
   localparam logic [2:0] REL_LE = 3'd3;
   localparam logic [2:0] REL_GT = 3'd4;
   localparam logic [2:0] REL_GE = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } rel_state_e;

   // Maps the accumulated less-than / equal flags onto the requested relation.
   function automatic logic rel_eval(input logic [2:0] op, input logic lt, input logic eq);
      logic res;
      case (op)
         REL_EQ:  res = eq;
         REL_NE:  res = ~eq;
         REL_LT:  res = lt;
         REL_LE:  res = lt | eq;
         REL_GT:  res = ~lt & ~eq;
         REL_GE:  res = ~lt;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rel_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-wide slice pair.
module rel_chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   output logic             o_lt,
   output logic             o_eq
);

   assign o_lt = (i_a < i_b);
   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/rel_compare_unit.sv
// Multi-cycle MSB-first relational comparator with valid/ready handshakes.
// Define REL_CMP_EARLY_EXIT_EN to leave BUSY on the first differing slice.
module rel_compare_unit
   import rel_cmp_pkg::*;
#(
   parameter int WIDTH = REL_DEF_WIDTH,
   parameter int CHUNK = REL_DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             z,
   output logic             n
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   rel_state_e        r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [2:0]        r_op;
   logic [IDXW-1:0]   r_idx;
   logic              r_lt;
   logic              r_eq;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_result;
   logic              r_z;
   logic              r_n;

   logic [CHUNK-1:0]  w_sa;
   logic [CHUNK-1:0]  w_sb;
   logic              w_clt;
   logic              w_ceq;
   logic              w_lt_nxt;
   logic              w_eq_nxt;
   logic              w_last;
   logic              w_res;

   rel_chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
      .i_a  (w_sa),
      .i_b  (w_sb),
      .o_lt (w_clt),
      .o_eq (w_ceq)
   );

   // Slice select, first-difference tracking and end-of-scan detection.
   always_comb begin
      w_sa = r_a[r_idx*CHUNK +: CHUNK];
      w_sb = r_b[r_idx*CHUNK +: CHUNK];
      if (r_eq && !w_ceq) begin
         w_lt_nxt = w_clt;
         w_eq_nxt = 1'b0;
      end else begin
         w_lt_nxt = r_lt;
         w_eq_nxt = r_eq;
      end
`ifdef REL_CMP_EARLY_EXIT_EN
      w_last = (r_idx == IDXW'(0)) || (r_eq && !w_ceq);
`else
      w_last = (r_idx == IDXW'(0));
`endif
      w_res = rel_eval(r_op, w_lt_nxt, w_eq_nxt);
   end

   // Control FSM with registered handshake and flag outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_op        <= 3'd0;
         r_idx       <= IDXW'(0);
         r_lt        <= 1'b0;
         r_eq        <= 1'b1;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= 1'b0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  // Flipping the sign bit turns a signed order into an unsigned one.
                  r_a        <= a ^ (is_signed ? MSB_MASK : {WIDTH{1'b0}});
                  r_b        <= b ^ (is_signed ? MSB_MASK : {WIDTH{1'b0}});
                  r_op       <= op;
                  r_idx      <= IDXW'(NCHUNK - 1);
                  r_lt       <= 1'b0;
                  r_eq       <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_BUSY;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_BUSY: begin
               r_lt <= w_lt_nxt;
               r_eq <= w_eq_nxt;
               if (w_last) begin
                  r_result    <= w_res;
                  r_z         <= ~w_res;
                  r_n         <= w_lt_nxt;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign z         = r_z;
   assign n         = r_n;

endmodule

// File: tb/tb_rel_compare_unit.sv
// Directed self-checking bench for rel_compare_unit (WIDTH=32, CHUNK=8).
module tb_rel_compare_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic        result;
   logic        z;
   logic        n;

   int total = 0;
   int bad   = 0;

`ifdef REL_CMP_EARLY_EXIT_EN
   localparam int LAT_MSB_DIFF = 1;
`else
   localparam int LAT_MSB_DIFF = 4;
`endif

   rel_compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .z         (z),
      .n         (n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xop,
                        input logic xs, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      a = xa; b = xb; op = xop; is_signed = xs; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      total++; if ({out_valid, result, z, n} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {out_valid, result, z, n}); end
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_le_unsigned();
      int lat;
      issue(32'd1, 32'd1, 3'd3, 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL le_u_lat got=%0d exp=4", lat); end
      total++; if ({result, z, n} !== 3'b100) begin bad++; $display("FAIL le_u_flags got=%b exp=100", {result, z, n}); end
      release_out();
   endtask

   task automatic test_le_signed();
      int lat;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'd3, 1'b1, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL le_s_lat got=%0d exp=4", lat); end
      total++; if ({result, z, n} !== 3'b010) begin bad++; $display("FAIL le_s_flags got=%b exp=010", {result, z, n}); end
      release_out();
   endtask

   task automatic test_lt_msb();
      int lat;
      issue(32'h8000_0000, 32'h0000_0001, 3'd2, 1'b0, lat);
      total++; if (lat !== LAT_MSB_DIFF) begin bad++; $display("FAIL lt_u_lat got=%0d exp=%0d", lat, LAT_MSB_DIFF); end
      total++; if ({result, z, n} !== 3'b010) begin bad++; $display("FAIL lt_u_flags got=%b exp=010", {result, z, n}); end
      release_out();
      issue(32'h8000_0000, 32'h0000_0001, 3'd2, 1'b1, lat);
      total++; if (lat !== LAT_MSB_DIFF) begin bad++; $display("FAIL lt_s_lat got=%0d exp=%0d", lat, LAT_MSB_DIFF); end
      total++; if ({result, z, n} !== 3'b101) begin bad++; $display("FAIL lt_s_flags got=%b exp=101", {result, z, n}); end
      release_out();
   endtask

   task automatic test_ops_sweep();
      int lat;
      logic [7:0] exp_tab;
      logic [2:0] o;
      // bit k = expected result for op k with a=5, b=9 unsigned
      exp_tab = 8'b0000_1110;
      for (int i = 0; i < 8; i++) begin
         o = 3'(i);
         issue(32'd5, 32'd9, o, 1'b0, lat);
         total++; if (lat !== 4) begin bad++; $display("FAIL sweep_lat op=%0d got=%0d exp=4", i, lat); end
         total++;
         if ({result, z, n} !== {exp_tab[i], ~exp_tab[i], 1'b1}) begin
            bad++;
            $display("FAIL sweep_flags op=%0d got=%b exp=%b", i, {result, z, n}, {exp_tab[i], ~exp_tab[i], 1'b1});
         end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      issue(32'd5, 32'd9, 3'd2, 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL bp_lat got=%0d exp=4", lat); end
      a = 32'd3; b = 32'd3; op = 3'd0; is_signed = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({out_valid, result, z, n, in_ready} !== 5'b11010) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got=%b exp=11010", i, {out_valid, result, z, n, in_ready});
         end
      end
      release_out();
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_after_hs got=%b exp=01", {out_valid, in_ready}); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got=%0b exp=0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++; if (lat !== 4) begin bad++; $display("FAIL bp2_lat got=%0d exp=4", lat); end
      total++; if ({result, z, n} !== 3'b100) begin bad++; $display("FAIL bp2_flags got=%b exp=100", {result, z, n}); end
      release_out();
   endtask

   task automatic test_reset_busy();
      int lat;
      a = 32'd1; b = 32'd2; op = 3'd5; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if ({out_valid, result, z, n, in_ready} !== 5'b00000) begin
         bad++;
         $display("FAIL rst_busy got=%b exp=00000", {out_valid, result, z, n, in_ready});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL rst_busy_idle got=%b exp=10", {in_ready, out_valid}); end
      issue(32'd7, 32'd7, 3'd5, 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL ge_eq_lat got=%0d exp=4", lat); end
      total++; if ({result, z, n} !== 3'b100) begin bad++; $display("FAIL ge_eq_flags got=%b exp=100", {result, z, n}); end
      release_out();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; op = 3'd0;
      is_signed = 1'b0; out_ready = 1'b0;
      test_reset();
      test_le_unsigned();
      test_le_signed();
      test_lt_msb();
      test_ops_sweep();
      test_backpressure();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rel_compare_unit.md
Name: rel_compare_unit

Overview:
Parametrised multi-cycle relational comparator and successor to the single-function less-or-equal block. It supports six relational ops, signed and unsigned operands, and configurable width. Operands are compared MSB-first, one CHUNK-bit slice per cycle, so wide compares meet timing in the ALU/CU datapath. It uses a valid/ready handshake on input and output and drives the ALU status flags z and n.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, NCHUNK >= 1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and op valid
in_ready  output  1  unit can accept; high only in IDLE
a  input  WIDTH  left operand
b  input  WIDTH  right operand
op  input  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved
is_signed  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
result  output  1  1 when "a op b" is true
z  output  1  equals ~result (team flag convention)
n  output  1  1 when a < b in the selected signedness, independent of op

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE; result, z, n and out_valid go to 0, in_ready goes to 0 while rst is high and 1 after. Reset mid-BUSY or mid-DONE abandons the operation with no output.
- IDLE: in_ready=1. On in_valid&&in_ready, a, b, op and is_signed are registered, idx=NCHUNK-1, lt_r=0, eq_r=1, and the state goes to BUSY. Inputs are ignored in all other states.
- Signed mode: the MSB of both registered operands is inverted before slicing, so an unsigned compare yields the signed order.
- BUSY: each cycle compares slice idx.
  - If eq_r is still 1 and the slices differ: lt_r = (slice_a < slice_b) and eq_r = 0.
  - Slices below the first difference never change lt_r.
  - Go to DONE when idx==0, or (EARLY_EXIT_EN) when the first difference is found; otherwise idx decrements.
- Result computed on entry to DONE, from lt_r and eq_r:
  - EQ = eq_r; NE = ~eq_r.
  - LT = lt_r; LE = lt_r|eq_r.
  - GT = ~lt_r&~eq_r; GE = ~lt_r.
  - Reserved op gives result=0.
  - n = lt_r; z = ~result. result, z and n are registered and stable throughout DONE.
- DONE: out_valid=1. On out_ready the state returns to IDLE. result, z and n hold their last values until the next DONE entry. out_valid drops the cycle after the handshake. No same-cycle back-to-back accept: in_ready rises in the cycle after the output handshake.
- Latency: from the accept edge to out_valid is NCHUNK cycles without early exit. With early exit it is k cycles, where k = 1 + number of equal leading slices.
- NCHUNK=1 degenerates to a single BUSY cycle.

Optional Feature:
Macro REL_CMP_EARLY_EXIT_EN.
- Defined: BUSY exits to DONE on the first differing slice, giving variable latency 1..NCHUNK.
- Undefined: BUSY always runs NCHUNK cycles, giving constant, data-independent latency.
- Results are identical either way.

Decomposition:
- Package rel_cmp_pkg holds:
  - op encodings REL_EQ..REL_GE as localparams or an enum.
  - state enum IDLE/BUSY/DONE.
  - default WIDTH/CHUNK constants.
- Sub-module rel_chunk_cmp: purely combinational, takes a CHUNK-wide slice pair and returns lt and eq. It is instantiated once and muxed by idx.

Test Plan (WIDTH=32, CHUNK=8):
- LE, unsigned, a=1, b=1, out_ready=1 -> result=1, z=0, n=0, out_valid exactly 4 cycles after accept in both builds.
- LE, signed, a=-1 (FFFFFFFF), b=-2 (FFFFFFFE) -> result=0, z=1, n=0, latency 4 in both builds (difference only in the low slice).
- LT, a=32'h80000000, b=1:
  - unsigned -> result=0, n=0.
  - signed -> result=1, n=1, z=0.
  - Latency 1 with REL_CMP_EARLY_EXIT_EN, 4 without.
- Ops sweep on a=5, b=9 unsigned:
  - EQ=0, NE=1, LT=1, LE=1, GT=0, GE=0.
  - op=7 -> result=0, z=1, n=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, result, z and n stable and in_ready=0; a new in_valid during this time is ignored; accept occurs the cycle after the handshake.
- Assert rst for 1 cycle during BUSY (idx=2) -> IDLE immediately, out_valid=0, result/z/n=0, then a fresh GE a=b=7 -> result=1.
